// File: rtl/debounce_fsm_if.sv
// Signal bundle between the switch debouncer and its neighbours: the synchronized
// switch level and counter clear flow in, the clean level, ticks and bounce count flow out.
interface debounce_fsm_if;
   logic       sw_sync;
   logic       clr;
   logic       db_level;
   logic       db_tick_rise;
   logic       db_tick_fall;
   logic [7:0] bounce_cnt;

   modport master (
      output sw_sync,
      output clr,
      input  db_level,
      input  db_tick_rise,
      input  db_tick_fall,
      input  bounce_cnt
   );

   modport slave (
      input  sw_sync,
      input  clr,
      output db_level,
      output db_tick_rise,
      output db_tick_fall,
      output bounce_cnt
   );
endinterface

// File: rtl/debounce_fsm.sv
// Switch debouncer: a four-state FSM with an N-bit down-counter stability window,
// clean level plus rise/fall ticks, and a saturating count of rejected bounces.
module debounce_fsm #(
   parameter int unsigned N = 20
) (
   input  logic          clk,
   input  logic          reset,
   debounce_fsm_if.slave bus
);

   // One-hot encoding leaves spare codes so corrupted state is detectable.
   typedef enum logic [3:0] {
      ZERO  = 4'b0001,
      WAIT1 = 4'b0010,
      ONE   = 4'b0100,
      WAIT0 = 4'b1000
   } state_t;

   logic [3:0]   state_q;
   state_t       state_d;
   logic [N-1:0] q_q;
   logic [N-1:0] q_d;
   logic         rise_q;
   logic         rise_d;
   logic         fall_q;
   logic         fall_d;
   logic         bounce;
   logic [7:0]   cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ZERO;
         q_q     <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Clear has priority over a bounce landing on the same edge.
   always_ff @(posedge clk) begin
      if (reset || bus.clr) begin
         cnt_q <= '0;
      end else if (bounce && (cnt_q != 8'hFF)) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   always_comb begin
      state_d = ZERO;
      q_d     = q_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      bounce  = 1'b0;
      case (state_q)
         ZERO: begin
            if (bus.sw_sync) begin
               state_d = WAIT1;
               q_d     = '1;
            end else begin
               state_d = ZERO;
            end
         end
         WAIT1: begin
            if (!bus.sw_sync) begin
               state_d = ZERO;
               bounce  = 1'b1;
            end else if (q_q == '0) begin
               state_d = ONE;
               rise_d  = 1'b1;
            end else begin
               state_d = WAIT1;
               q_d     = q_q - N'(1);
            end
         end
         ONE: begin
            if (!bus.sw_sync) begin
               state_d = WAIT0;
               q_d     = '1;
            end else begin
               state_d = ONE;
            end
         end
         WAIT0: begin
            if (bus.sw_sync) begin
               state_d = ONE;
               bounce  = 1'b1;
            end else if (q_q == '0) begin
               state_d = ZERO;
               fall_d  = 1'b1;
            end else begin
               state_d = WAIT0;
               q_d     = q_q - N'(1);
            end
         end
         default: begin
            state_d = ZERO;
         end
      endcase
   end

   assign bus.db_level     = (state_q == ONE) || (state_q == WAIT0);
   assign bus.db_tick_rise = rise_q;
   assign bus.db_tick_fall = fall_q;
   assign bus.bounce_cnt   = cnt_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Scoreboard bench for debounce_fsm: a run-length reference model predicts every
// cycle's outputs, and an independent monitor compares them one edge later.
module tb_debounce_fsm;
   localparam int unsigned N      = 3;
   localparam int unsigned ACCEPT = (1 << N) + 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   debounce_fsm_if dbif ();

   debounce_fsm #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dbif)
   );

   typedef struct {
      bit          level;
      bit          rise;
      bit          fall;
      int unsigned cnt;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   int          vectors     = 0;
   int          miscompares = 0;

   // Reference model: current clean level, length of the current run of opposite samples.
   bit          m_level = 1'b0;
   int unsigned m_run   = 0;
   int unsigned m_cnt   = 0;

   task automatic step(input bit sw, input bit clr_in, input bit rst_in,
                       input bit illegal, input string tag);
      exp_t e;
      bit   bnc;
      @(negedge clk);
      dbif.sw_sync = sw;
      dbif.clr     = clr_in;
      reset        = rst_in;
      if (illegal) dut.state_q = 4'b0110;
      e.rise = 1'b0;
      e.fall = 1'b0;
      bnc    = 1'b0;
      if (rst_in) begin
         m_level = 1'b0;
         m_run   = 0;
         m_cnt   = 0;
      end else begin
         if (illegal) begin
            m_level = 1'b0;
            m_run   = 0;
         end else if (sw != m_level) begin
            m_run++;
            if (m_run == ACCEPT) begin
               m_level = sw;
               m_run   = 0;
               if (sw) e.rise = 1'b1;
               else    e.fall = 1'b1;
            end
         end else begin
            bnc   = (m_run != 0);
            m_run = 0;
         end
         if (clr_in)                    m_cnt = 0;
         else if (bnc && m_cnt < 255)   m_cnt++;
      end
      e.level = m_level;
      e.cnt   = m_cnt;
      e.tag   = tag;
      sb.push_back(e);
   endtask

   task automatic hold(input bit sw, input int unsigned cycles, input string tag);
      for (int unsigned i = 0; i < cycles; i++) step(sw, 1'b0, 1'b0, 1'b0, tag);
   endtask

   // Monitor: every cycle is an output beat, so pop one expectation per edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (dbif.db_level !== e.level || dbif.db_tick_rise !== e.rise ||
                dbif.db_tick_fall !== e.fall || dbif.bounce_cnt !== 8'(e.cnt)) begin
               miscompares++;
               $display("FAIL %s @%0t: level/rise/fall/cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                        e.tag, $time, dbif.db_level, dbif.db_tick_rise, dbif.db_tick_fall,
                        dbif.bounce_cnt, e.level, e.rise, e.fall, e.cnt);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      bit sw;
      bit done;
      dbif.sw_sync = 1'b0;
      dbif.clr     = 1'b0;
      reset        = 1'b1;

      for (int unsigned i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "reset");
      hold(1'b0, 20, "idle_low");

      hold(1'b1, 15, "clean_rise");
      hold(1'b0, 15, "clean_fall");

      step(1'b1, 1'b0, 1'b0, 1'b0, "bounce_pat");
      step(1'b1, 1'b0, 1'b0, 1'b0, "bounce_pat");
      step(1'b0, 1'b0, 1'b0, 1'b0, "bounce_pat");
      step(1'b1, 1'b0, 1'b0, 1'b0, "bounce_pat");
      step(1'b1, 1'b0, 1'b0, 1'b0, "bounce_pat");
      step(1'b1, 1'b0, 1'b0, 1'b0, "bounce_pat");
      step(1'b0, 1'b0, 1'b0, 1'b0, "bounce_pat");
      hold(1'b1, 12, "bounce_settle");
      hold(1'b0, 12, "back_low");

      sw = 1'b0;
      for (int unsigned i = 0; i < 1200; i++) begin
         if (i % 2 == 0) sw = ~sw;
         step(sw, 1'b0, 1'b0, 1'b0, "chatter_sat");
      end

      // Assert clr on an edge the model predicts will also count a bounce.
      done = 1'b0;
      for (int unsigned i = 0; i < 16 && !done; i++) begin
         if (i % 2 == 0) sw = ~sw;
         if (sw == m_level && m_run != 0) begin
            step(sw, 1'b1, 1'b0, 1'b0, "clr_vs_bounce");
            done = 1'b1;
         end else begin
            step(sw, 1'b0, 1'b0, 1'b0, "chatter_clr");
         end
      end
      hold(1'b0, 12, "post_clr");

      hold(1'b1, 12, "to_one");
      step(1'b1, 1'b0, 1'b1, 1'b0, "reset_in_one");
      hold(1'b1, 15, "rerise_after_reset");

      step(1'b1, 1'b0, 1'b0, 1'b1, "illegal_state");
      hold(1'b1, 12, "rerise_after_illegal");
      hold(1'b0, 12, "fall_after_illegal");

      for (int unsigned seg = 0; seg < 60; seg++) begin
         int unsigned len;
         sw  = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 12);
         for (int unsigned i = 0; i < len; i++) begin
            step(sw, ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0), 1'b0, "random");
         end
      end

      for (int unsigned i = 0; i < 8 && sb.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
